dla_debug_network_master: RTL and testbench

- Ring head of the debug network: accepts one CSR-side read request at a time and injects its address onto the ring.
- Waits for the matching read response to come back around the ring, with a timeout, and caches the data plus a status for runtime polling.
- Discards the returning address beat and any response not tied to an outstanding request.
- Sits between the CSR block and the first and last ring nodes.

---
 rtl/dla_debug_network_master.sv | 142 ++++++++++++++
 tb/tb_dla_debug_network_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dla_debug_network_master.sv
// Debug network ring head: issues one CSR read address onto the ring, waits
// for the matching data beat to come back around (bounded by a timeout) and
// caches the outcome for runtime polling. Stray responses are counted.
module dla_debug_network_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int BUS_WIDTH     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
    localparam int CNT_WIDTH     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  i_aresetn,
    input  logic                  i_rd_valid,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_status_clear,
    output logic [7:0]            o_spurious_count,
    output logic                  o_down_forced_valid,
    output logic [BUS_WIDTH-1:0]  o_down_shared_bus,
    output logic                  o_down_is_addr,
    input  logic                  i_up_forced_valid,
    input  logic [BUS_WIDTH-1:0]  i_up_shared_bus,
    input  logic                  i_up_is_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_done;
    logic                  r_timeout;
    logic [DATA_WIDTH-1:0] r_data;
    logic [7:0]            r_spur;
    logic                  r_down_valid;
    logic                  r_down_is_addr;
    logic [BUS_WIDTH-1:0]  r_down_bus;

    logic w_ready;
    logic w_accept;
    logic w_up_resp;
    logic w_timeout_hit;

    assign w_ready       = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept      = i_rd_valid & w_ready;
    // Only data beats matter; our own address returning is never a response.
    assign w_up_resp     = i_up_forced_valid & ~i_up_is_addr;
    assign w_timeout_hit = (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    assign o_rd_ready          = w_ready;
    assign o_busy              = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign o_done              = r_done;
    assign o_timeout           = r_timeout;
    assign o_data              = r_data;
    assign o_spurious_count    = r_spur;
    assign o_down_forced_valid = r_down_valid;
    assign o_down_is_addr      = r_down_is_addr;
    assign o_down_shared_bus   = r_down_bus;

    // Request FSM: issue beat, response wait with timeout, cached status.
    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_data         <= '0;
            r_down_valid   <= 1'b0;
            r_down_is_addr <= 1'b0;
            r_down_bus     <= '0;
        end else if (w_accept) begin
            // New request from IDLE or DONE: drive the address beat next cycle.
            r_state        <= S_ISSUE;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_down_valid   <= 1'b1;
            r_down_is_addr <= 1'b1;
            r_down_bus     <= BUS_WIDTH'(i_rd_addr);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_ISSUE: begin
                    // Address beat lasts exactly one cycle.
                    r_state        <= S_WAIT;
                    r_cnt          <= '0;
                    r_down_valid   <= 1'b0;
                    r_down_is_addr <= 1'b0;
                    r_down_bus     <= '0;
                end
                S_WAIT: begin
                    if (w_up_resp) begin
                        // A response beats a coincident timeout.
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b0;
                        r_data    <= i_up_shared_bus[DATA_WIDTH-1:0];
                    end else if (w_timeout_hit) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_data    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (i_status_clear) begin
                        // Data stays readable after the status is acknowledged.
                        r_state   <= S_IDLE;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating count of data beats arriving with no request waiting.
    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_spur <= 8'd0;
        end else if (w_up_resp && (r_state != S_WAIT) && (r_spur != 8'hFF)) begin
            r_spur <= r_spur + 8'd1;
        end else begin
            r_spur <= r_spur;
        end
    end

endmodule

// File: tb/tb_dla_debug_network_master.sv
// Scoreboard bench for dla_debug_network_master with a small ring model.
module tb_dla_debug_network_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          i_aresetn;
    logic          i_rd_valid;
    logic [AW-1:0] i_rd_addr;
    logic          o_rd_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_timeout;
    logic [DW-1:0] o_data;
    logic          i_status_clear;
    logic [7:0]    o_spurious_count;
    logic          o_down_forced_valid;
    logic [31:0]   o_down_shared_bus;
    logic          o_down_is_addr;
    logic          i_up_forced_valid;
    logic [31:0]   i_up_shared_bus;
    logic          i_up_is_addr;

    always #5 clk = ~clk;

    dla_debug_network_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk                (clk),
        .i_aresetn          (i_aresetn),
        .i_rd_valid         (i_rd_valid),
        .i_rd_addr          (i_rd_addr),
        .o_rd_ready         (o_rd_ready),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_timeout          (o_timeout),
        .o_data             (o_data),
        .i_status_clear     (i_status_clear),
        .o_spurious_count   (o_spurious_count),
        .o_down_forced_valid(o_down_forced_valid),
        .o_down_shared_bus  (o_down_shared_bus),
        .o_down_is_addr     (o_down_is_addr),
        .i_up_forced_valid  (i_up_forced_valid),
        .i_up_shared_bus    (i_up_shared_bus),
        .i_up_is_addr       (i_up_is_addr)
    );

    typedef struct packed {
        logic        done;
        logic        tmo;
        logic [31:0] data;
        logic [31:0] lat;
    } res_t;

    res_t        res_q[$];
    logic [31:0] addr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_spur = 0;
    logic [31:0] exp_data = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic spur_event(input int n);
        exp_spur = (exp_spur + n > 255) ? 255 : exp_spur + n;
    endtask

    task automatic up_idle();
        i_up_forced_valid = 1'b0;
        i_up_is_addr      = 1'b0;
        i_up_shared_bus   = 32'd0;
    endtask

    task automatic up_beat(input logic is_addr, input logic [31:0] val);
        i_up_forced_valid = 1'b1;
        i_up_is_addr      = is_addr;
        i_up_shared_bus   = val;
    endtask

    // One request: k = WAIT cycle carrying the response (k >= T means none
    // in time, a late one is injected after DONE); lp = WAIT cycle of the
    // looped-back address (-1 none). Called and returns at a negedge.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input int k,
                           input int lp, input bit hold, input bit clr);
        res_t r;
        int   w;
        bit   fin;
        bit   hit;
        hit    = (k < T);
        r.done = hit;
        r.tmo  = !hit;
        r.data = hit ? data : 32'd0;
        r.lat  = hit ? 32'(k + 2) : 32'(T + 1);
        addr_q.push_back(addr);
        res_q.push_back(r);
        i_rd_addr  = addr;
        i_rd_valid = 1'b1;
        w = 0;
        while (!o_rd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", o_rd_ready, 1);
        @(negedge clk);
        if (!hold) i_rd_valid = 1'b0;
        up_idle();
        fin = 1'b0;
        for (int c = 0; c < T + 6 && !fin; c++) begin
            @(negedge clk);
            up_idle();
            if (!o_busy) fin = 1'b1;
            else if (c == lp) up_beat(1'b1, addr);
            else if (c == k && hit) up_beat(1'b0, data);
        end
        check("txn_completes", fin, 1);
        exp_data = r.data;
        if (!hit) begin
            up_beat(1'b0, $urandom);
            spur_event(1);
        end
        if (!hold) begin
            @(negedge clk);
            up_idle();
            check("spur_count", o_spurious_count, 64'(exp_spur));
            check("data_held", o_data, exp_data);
            if (clr) begin
                i_status_clear = 1'b1;
                @(negedge clk);
                i_status_clear = 1'b0;
                check("clr_done", o_done, 0);
                check("clr_timeout", o_timeout, 0);
                check("clr_data_kept", o_data, exp_data);
                check("clr_ready", o_rd_ready, 1);
            end
        end
    endtask

    // Monitor: checks every ring issue beat and every completed request.
    initial begin : monitor
        int   cyc;
        int   issue_cyc;
        bit   prev_busy;
        bit   prev_dv;
        res_t r;
        cyc       = 0;
        issue_cyc = 0;
        prev_busy = 1'b0;
        prev_dv   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (i_aresetn) begin
                if (o_down_forced_valid) begin
                    check("issue_single_cycle", prev_dv, 0);
                    if (addr_q.size() == 0) begin
                        check("issue_unrequested", 1, 0);
                    end else begin
                        check("issue_bus", o_down_shared_bus, addr_q.pop_front());
                        check("issue_is_addr", o_down_is_addr, 1);
                        issue_cyc = cyc;
                    end
                end else begin
                    check("ring_quiet", {o_down_is_addr, o_down_shared_bus}, 0);
                end
                check("ready_vs_busy", o_rd_ready, !o_busy);
                if (o_busy) check("status_clear_when_busy", {o_done, o_timeout}, 0);
                if (prev_busy && !o_busy) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        r = res_q.pop_front();
                        check("latency", 32'(cyc - issue_cyc), r.lat);
                        check("done", o_done, r.done);
                        check("timeout", o_timeout, r.tmo);
                        check("data", o_data, r.data);
                    end
                end
            end
            prev_busy = o_busy;
            prev_dv   = o_down_forced_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit hold_prev;
        bit hold;
        int k;
        int lp;
        i_aresetn      = 1'b0;
        i_rd_valid     = 1'b0;
        i_rd_addr      = 32'd0;
        i_status_clear = 1'b0;
        up_idle();
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_data", o_data, 0);
        check("rst_spur", o_spurious_count, 0);
        check("rst_ring", {o_down_forced_valid, o_down_is_addr, o_down_shared_bus}, 0);
        repeat (3) @(negedge clk);
        i_aresetn = 1'b1;
        @(negedge clk);

        // Directed: loopback after 3 cycles, data 5 cycles later.
        run_txn(32'h0300_0010, 32'hCAFE_F00D, 7, 2, 1'b0, 1'b0);
        // Timeout with a late response afterwards.
        run_txn(32'h0400_0020, 32'h1234_5678, 99, 5, 1'b0, 1'b1);
        // Response exactly on the timeout cycle.
        run_txn(32'h0500_0030, 32'hA5A5_5A5A, T - 1, 3, 1'b0, 1'b0);
        // Valid held high through WAIT, back-to-back acceptance in DONE.
        run_txn(32'h0600_0040, 32'h0BAD_BEEF, 4, 1, 1'b1, 1'b0);
        run_txn(32'h0700_0050, 32'h7777_0000, T + 2, 2, 1'b1, 1'b0);
        run_txn(32'h0800_0060, 32'h8888_1111, 0, -1, 1'b0, 1'b1);

        // Randomized traffic.
        hold_prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            k    = $urandom_range(0, T + 3);
            lp   = (k > 0 && $urandom_range(0, 1) == 1) ?
                   $urandom_range(0, ((k < T) ? k : T) - 1) : -1;
            hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_txn($urandom, $urandom, k, lp, hold, (i == 39) ? 1'b1 : 1'($urandom_range(0, 1)));
            hold_prev = hold;
        end

        // Flood of unsolicited responses while idle, plus ignored address beats.
        for (int i = 0; i < 300; i++) begin
            up_beat(1'b0, $urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            up_beat(1'b1, $urandom);
            @(negedge clk);
        end
        up_idle();
        @(negedge clk);
        spur_event(300);
        check("spur_saturated", o_spurious_count, 64'(exp_spur));
        check("flood_idle_busy", o_busy, 0);
        check("flood_idle_ready", o_rd_ready, 1);
        check("flood_done", o_done, 0);

        // Asynchronous reset in the middle of WAIT.
        addr_q.push_back(32'h0900_0070);
        i_rd_addr  = 32'h0900_0070;
        i_rd_valid = 1'b1;
        @(negedge clk);
        i_rd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", o_busy, 1);
        #2;
        i_aresetn = 1'b0;
        #1;
        exp_spur = 0;
        exp_data = 32'd0;
        check("arst_busy", o_busy, 0);
        check("arst_done", {o_done, o_timeout}, 0);
        check("arst_data", o_data, 0);
        check("arst_spur", o_spurious_count, 0);
        check("arst_ring", {o_down_forced_valid, o_down_is_addr, o_down_shared_bus}, 0);
        @(negedge clk);
        @(negedge clk);
        i_aresetn = 1'b1;
        @(negedge clk);
        up_beat(1'b0, 32'hDEAD_0001);
        spur_event(1);
        @(negedge clk);
        up_idle();
        @(negedge clk);
        check("post_reset_spur", o_spurious_count, 64'(exp_spur));
        check("post_reset_data", o_data, 0);
        check("post_reset_done", o_done, 0);

        check("scoreboard_empty", 64'(res_q.size() + addr_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
